// File: rtl/restador_serie.sv
// Bit-serial N-bit subtractor (D = A - B - Bin), LSB first, through one full-subtractor
// cell built from power-counted gate primitives, under a start/busy/done handshake.

module xor3_p #(
  parameter int PwrC = 0
) (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  // The power class only tags the instance for power annotation; logic is identical.
  if (PwrC >= 0) begin : g_core
    assign y = a ^ b ^ c;
  end else begin : g_core
    assign y = a ^ b ^ c;
  end
endmodule

module and2_p #(
  parameter int PwrC = 0
) (
  input  logic a,
  input  logic b,
  output logic y
);
  if (PwrC >= 0) begin : g_core
    assign y = a & b;
  end else begin : g_core
    assign y = a & b;
  end
endmodule

module or3_p #(
  parameter int PwrC = 0
) (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  if (PwrC >= 0) begin : g_core
    assign y = a | b | c;
  end else begin : g_core
    assign y = a | b | c;
  end
endmodule

module inv_p #(
  parameter int PwrC = 0
) (
  input  logic a,
  output logic y
);
  if (PwrC >= 0) begin : g_core
    assign y = ~a;
  end else begin : g_core
    assign y = ~a;
  end
endmodule

module restador_serie #(
  parameter int PwrC = 0,
  parameter int N    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bo
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   ra_reg, rb_reg, d_reg;
  logic           borrow_reg, bo_reg;
  logic [CW-1:0]  cnt_reg;

  logic diff, nra, t_ab, t_aw, t_bw, borrow_next;

  // Single full-subtractor cell working on the LSBs of the operand shifters.
  xor3_p #(.PwrC(PwrC)) u_xor  (.a(ra_reg[0]), .b(rb_reg[0]), .c(borrow_reg), .y(diff));
  inv_p  #(.PwrC(PwrC)) u_inv  (.a(ra_reg[0]), .y(nra));
  and2_p #(.PwrC(PwrC)) u_and0 (.a(nra),       .b(rb_reg[0]),  .y(t_ab));
  and2_p #(.PwrC(PwrC)) u_and1 (.a(nra),       .b(borrow_reg), .y(t_aw));
  and2_p #(.PwrC(PwrC)) u_and2 (.a(rb_reg[0]), .b(borrow_reg), .y(t_bw));
  or3_p  #(.PwrC(PwrC)) u_or   (.a(t_ab), .b(t_aw), .c(t_bw), .y(borrow_next));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt_reg == CW'(N - 1)) state_next = FIN;
      end
      FIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // bo tracks the running borrow only while shifting, so it stays put outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_reg     <= '0;
      rb_reg     <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      bo_reg     <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          ra_reg     <= a;
          rb_reg     <= b;
          borrow_reg <= bi;
          cnt_reg    <= '0;
        end
        RUN: begin
          ra_reg     <= ra_reg >> 1;
          rb_reg     <= rb_reg >> 1;
          d_reg      <= {diff, d_reg[N-1:1]};
          borrow_reg <= borrow_next;
          bo_reg     <= borrow_next;
          cnt_reg    <= cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign d  = d_reg;
  assign bo = bo_reg;
endmodule

// File: tb/tb_restador_serie.sv
// Directed bench for restador_serie: vector table of single operations plus
// hand-written sequences for held start, mid-run reset and output stability.

module tb_restador_serie;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, start, bi;
  logic [N-1:0] a, b;
  logic         busy, done, bo;
  logic [N-1:0] d;

  int checks   = 0;
  int failures = 0;

  restador_serie #(.PwrC(0), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bi(bi),
    .busy(busy), .done(done), .d(d), .bo(bo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bi;
    logic [N-1:0] exp_d;
    logic         exp_bo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: start sampled at E0, done expected after edge E8, busy for N+1 cycles.
  task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vbi,
                        input logic [N-1:0] ed, input logic ebo);
    int n, nb;
    logic [N-1:0] held;
    @(negedge clk);
    a = va; b = vb; bi = vbi; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va; b = va ^ vb; bi = ~vbi;
    n = 0; nb = 0;
    forever begin
      if (busy) nb++;
      if (done || n == 20) break;
      tick();
      n++;
    end
    check("done_latency", n, N);
    check("busy_cycles", nb, N + 1);
    check("d", d, ed);
    check("bo", bo, ebo);
    held = d;
    tick();
    check("done_width", done, 0);
    check("busy_after", busy, 0);
    repeat (3) tick();
    check("d_hold", d, held);
    $display("op a=%0d b=%0d bi=%0d -> d=%0d bo=%0d (exp %0d/%0d) latency=%0d", va, vb, vbi, held, bo, ed, ebo, n);
  endtask

  initial begin
    int cyc, ndone, nextra;
    int done_at[3];

    vecs[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
    vecs[1] = '{8'd37,  8'd100, 1'b0, 8'd193, 1'b1};
    vecs[2] = '{8'h00,  8'h00,  1'b1, 8'hFF,  1'b1};
    vecs[3] = '{8'hFF,  8'hFF,  1'b0, 8'h00,  1'b0};
    vecs[4] = '{8'd200, 8'd55,  1'b0, 8'd145, 1'b0};
    vecs[5] = '{8'h80,  8'h01,  1'b1, 8'h7E,  1'b0};
    vecs[6] = '{8'd5,   8'd5,   1'b1, 8'hFF,  1'b1};
    vecs[7] = '{8'hA5,  8'h5A,  1'b0, 8'h4B,  1'b0};
    done_at[0] = 8; done_at[1] = 18; done_at[2] = 28;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bo", bo, 0);
    $display("reset: busy=%0d done=%0d d=%0h bo=%0d", busy, done, d, bo);
    @(negedge clk) rst = 1'b0;

    // No done without an accepted start.
    nextra = 0;
    repeat (6) begin tick(); if (done || busy) nextra++; end
    check("idle_no_done", nextra, 0);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].exp_d, vecs[i].exp_bo);

    // Start held high: one result every N+2 cycles; a perturbed mid-run.
    @(negedge clk);
    a = 8'd200; b = 8'd55; bi = 1'b0; start = 1'b1;
    cyc = -1; ndone = 0;
    repeat (30) begin
      tick();
      cyc++;
      if (cyc == 3) a = 8'd0;
      if (cyc == 6) a = 8'd200;
      if (done) begin
        if (ndone < 3) check("held_done_cycle", cyc, done_at[ndone]);
        check("held_d", d, 145);
        check("held_bo", bo, 0);
        $display("held start: done at cycle %0d d=%0d bo=%0d", cyc, d, bo);
        ndone++;
      end
    end
    check("held_done_count", ndone, 3);
    start = 1'b0;
    repeat (12) tick();

    // Reset four cycles into RUN aborts the operation without a done pulse.
    @(negedge clk);
    a = 8'd100; b = 8'd37; bi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("pre_abort_busy", busy, 1);
    @(negedge clk) rst = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", d, 0);
    check("abort_bo", bo, 0);
    $display("abort: busy=%0d done=%0d d=%0h bo=%0d", busy, done, d, bo);
    @(negedge clk) rst = 1'b0;
    nextra = 0;
    repeat (12) begin tick(); if (done) nextra++; end
    check("abort_no_done", nextra, 0);

    run_op(8'd10, 8'd3, 1'b0, 8'd7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
